// File: rtl/sx_pkg.sv
// Shared widths, saturation limits and skid-state encoding for the 32->17 narrowing pipe.
package sx_pkg;

  localparam int unsigned IN_W_DEF  = 32;
  localparam int unsigned OUT_W_DEF = 17;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [OUT_W_DEF-1:0] SAT_POS = {1'b0, {(OUT_W_DEF - 1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] SAT_NEG = {1'b1, {(OUT_W_DEF - 1){1'b0}}};

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sx_narrow_core.sv
// Combinational fit test plus saturate/truncate select for one signed word.
module sx_narrow_core
  import sx_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             sat_en_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             ovf_o
);

  localparam logic [OUT_W-1:0] SatPos = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] SatNeg = {1'b1, {(OUT_W - 1){1'b0}}};

  logic [IN_W-OUT_W:0] hi_bits;
  logic                fits;

  // The value fits when every bit from the output sign bit upward is a copy of the sign.
  assign hi_bits = in_data_i[IN_W-1:OUT_W-1];
  assign fits    = (&hi_bits) | ~(|hi_bits);
  assign ovf_o   = ~fits;

  always_comb begin
    out_data_o = in_data_i[OUT_W-1:0];
    if (!fits && sat_en_i) begin
      out_data_o = in_data_i[IN_W-1] ? SatNeg : SatPos;
    end
  end

endmodule

// File: rtl/sx_narrow_pipe.sv
// Registered valid/ready narrowing stage with a one-entry skid slot and overflow statistics.
module sx_narrow_pipe
  import sx_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_ovf
);

  skid_state_e state_q, state_d;

  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_ovf_q, skid_ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [OUT_W-1:0] nar_data;
  logic             nar_ovf;
  logic             accept;
  logic             consume;

  sx_narrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data_i  (in_data),
    .sat_en_i   (sat_en),
    .out_data_o (nar_data),
    .ovf_o      (nar_ovf)
  );

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !consume) begin
          state_d = StTwo;
        end else if (!accept && consume) begin
          state_d = StEmpty;
        end
      end
      StTwo:   if (consume) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = in_ready_q;
    out_data  = out_data_q;
    out_ovf   = out_ovf_q;
  end

  // Data movement: new words land in the output register unless it is occupied and stays so.
  always_comb begin
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    skid_data_d = skid_data_q;
    skid_ovf_d  = skid_ovf_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          out_data_d = nar_data;
          out_ovf_d  = nar_ovf;
        end
      end
      StOne: begin
        if (accept && consume) begin
          out_data_d = nar_data;
          out_ovf_d  = nar_ovf;
        end else if (accept) begin
          skid_data_d = nar_data;
          skid_ovf_d  = nar_ovf;
        end
      end
      StTwo: begin
        if (consume) begin
          out_data_d = skid_data_q;
          out_ovf_d  = skid_ovf_q;
        end
      end
      default: ;
    endcase
    in_ready_d = (state_d != StTwo);
  end

  // Clear takes priority, but an overflow accepted on the same edge still counts.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (clr_ovf) begin
      sticky_d = accept & nar_ovf;
      count_d  = (accept & nar_ovf) ? CNT_W'(1) : '0;
    end else if (accept && nar_ovf) begin
      sticky_d = 1'b1;
      if (count_q != '1) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      skid_data_q <= '0;
      skid_ovf_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      skid_data_q <= skid_data_d;
      skid_ovf_q  <= skid_ovf_d;
      in_ready_q  <= in_ready_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: tb/tb_sx_narrow_pipe.sv
// Directed bench for sx_narrow_pipe with hand-computed expectations checked by immediate asserts.
module tb_sx_narrow_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_ovf;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;
  logic        clr_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sx_narrow_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .clr_ovf    (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then read 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sat_en    = 1'b1;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {15'd0, out_data}, 32'd0);
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("rst_count", {24'd0, ovf_count}, 32'd0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Values that fit, streamed back to back
    in_valid = 1'b1;
    in_data  = 32'h0000_FFFF;
    step();
    chk("fit0_valid", {31'd0, out_valid}, 32'd1);
    chk("fit0_data", {15'd0, out_data}, 32'h0_FFFF);
    chk("fit0_ovf", {31'd0, out_ovf}, 32'd0);
    in_data = 32'hFFFF_0000;
    step();
    chk("fit1_data", {15'd0, out_data}, 32'h1_0000);
    chk("fit1_ovf", {31'd0, out_ovf}, 32'd0);
    in_data = 32'h0000_0005;
    step();
    chk("fit2_data", {15'd0, out_data}, 32'h0_0005);
    chk("fit2_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("fit_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("fit_count", {24'd0, ovf_count}, 32'd0);

    // Saturating overflow
    in_valid = 1'b1;
    in_data  = 32'h0001_0000;
    step();
    chk("satp_data", {15'd0, out_data}, 32'h0_FFFF);
    chk("satp_ovf", {31'd0, out_ovf}, 32'd1);
    in_data = 32'h8000_0000;
    step();
    chk("satn_data", {15'd0, out_data}, 32'h1_0000);
    chk("satn_ovf", {31'd0, out_ovf}, 32'd1);
    chk("sat_count", {24'd0, ovf_count}, 32'd2);

    // Truncating overflow
    sat_en  = 1'b0;
    in_data = 32'h0003_2345;
    step();
    chk("trunc_data", {15'd0, out_data}, 32'h1_2345);
    chk("trunc_ovf", {31'd0, out_ovf}, 32'd1);
    chk("trunc_sticky", {31'd0, ovf_sticky}, 32'd1);
    chk("trunc_count", {24'd0, ovf_count}, 32'd3);
    in_valid = 1'b0;
    sat_en   = 1'b1;
    step();

    // Backpressure: A and B held, C refused until a slot frees
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0011;
    step();
    chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
    in_data = 32'h0000_0022;
    step();
    chk("bp_b_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_b_head", {15'd0, out_data}, 32'h0_0011);
    in_data = 32'hFFFF_FFFF;
    step();
    chk("bp_c_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_stall_data", {15'd0, out_data}, 32'h0_0011);
    out_ready = 1'b1;
    step();
    chk("bp_rel_b", {15'd0, out_data}, 32'h0_0022);
    chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_rel_c", {15'd0, out_data}, 32'h1_FFFF);
    chk("bp_rel_c_ovf", {31'd0, out_ovf}, 32'd0);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Counter saturation then clear coinciding with an overflowing accept
    in_valid = 1'b1;
    in_data  = 32'h7FFF_FFFF;
    for (int i = 0; i < 300; i++) step();
    chk("cnt_sat", {24'd0, ovf_count}, 32'hFF);
    chk("cnt_sat_data", {15'd0, out_data}, 32'h0_FFFF);
    clr_ovf = 1'b1;
    step();
    chk("clr_acc_count", {24'd0, ovf_count}, 32'd1);
    chk("clr_acc_sticky", {31'd0, ovf_sticky}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    chk("clr_count", {24'd0, ovf_count}, 32'd0);
    chk("clr_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("clr_held_ovf", {31'd0, out_ovf}, 32'd1);
    clr_ovf = 1'b0;

    // Reset while two words are held
    in_valid = 1'b1;
    in_data  = 32'h0000_1234;
    step();
    chk("rst2_full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_data", {15'd0, out_data}, 32'd0);
    chk("rst2_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst2_count", {24'd0, ovf_count}, 32'd0);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_after_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
